// File: rtl/uart_cmd_sched.sv
// uart_cmd_sched: frames bytes from the UART receiver into single-byte auth
// commands and 4-byte config writes. It applies backpressure to the receiver
// while a command is outstanding and aborts config frames that stall.
module uart_cmd_sched #(
  parameter int unsigned TMO_CYC = 1_000_000,
  parameter logic [7:0]  HDR_CFG = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rdy,
  output logic        auth_vld,
  output logic [7:0]  auth_byte,
  input  logic        auth_ack,
  output logic        cfg_vld,
  output logic [3:0]  cfg_addr,
  output logic [15:0] cfg_data,
  input  logic        cfg_ack,
  output logic        err_badhdr,
  output logic        err_tmo
);

  localparam int unsigned     CNT_W    = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [7:0] CMD_G = 8'h67;
  localparam logic [7:0] CMD_S = 8'h73;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AUTH_WAIT,
    S_CFG_ADDR,
    S_CFG_DH,
    S_CFG_DL,
    S_CFG_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              auth_vld_q, auth_vld_d;
  logic [7:0]        auth_byte_q, auth_byte_d;
  logic              cfg_vld_q, cfg_vld_d;
  logic [3:0]        cfg_addr_q, cfg_addr_d;
  logic [15:0]       cfg_data_q, cfg_data_d;
  logic              err_badhdr_q, err_badhdr_d;
  logic              err_tmo_q, err_tmo_d;
  logic              consume;
  logic              in_frame;

  // State register and registered outputs; everything clears asynchronously.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      auth_vld_q   <= 1'b0;
      auth_byte_q  <= '0;
      cfg_vld_q    <= 1'b0;
      cfg_addr_q   <= '0;
      cfg_data_q   <= '0;
      err_badhdr_q <= 1'b0;
      err_tmo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      auth_vld_q   <= auth_vld_d;
      auth_byte_q  <= auth_byte_d;
      cfg_vld_q    <= cfg_vld_d;
      cfg_addr_q   <= cfg_addr_d;
      cfg_data_q   <= cfg_data_d;
      err_badhdr_q <= err_badhdr_d;
      err_tmo_q    <= err_tmo_d;
    end
  end

  // Next-state, byte consumption and inter-byte timeout.
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    auth_vld_d   = auth_vld_q;
    auth_byte_d  = auth_byte_q;
    cfg_vld_d    = cfg_vld_q;
    cfg_addr_d   = cfg_addr_q;
    cfg_data_d   = cfg_data_q;
    err_badhdr_d = 1'b0;
    err_tmo_d    = 1'b0;
    consume      = 1'b0;

    in_frame = (state_q == S_CFG_ADDR) || (state_q == S_CFG_DH) ||
               (state_q == S_CFG_DL);

    // Inside a config frame, silence advances the counter; a byte always
    // beats the timeout, even in the cycle the last count is reached.
    if (in_frame && !rx_rdy) begin
      if (cnt_q == CNT_LAST) begin
        err_tmo_d = 1'b1;
        state_d   = S_IDLE;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (rx_rdy) begin
          consume = 1'b1;
          if (rx_data == CMD_G || rx_data == CMD_S) begin
            auth_byte_d = rx_data;
            auth_vld_d  = 1'b1;
            state_d     = S_AUTH_WAIT;
          end else if (rx_data == HDR_CFG) begin
            state_d = S_CFG_ADDR;
          end else begin
            err_badhdr_d = 1'b1;
          end
        end
      end
      S_AUTH_WAIT: begin
        if (auth_ack) begin
          auth_vld_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_CFG_ADDR: begin
        if (rx_rdy) begin
          consume = 1'b1;
          if (rx_data[7:4] == 4'h0) begin
            cfg_addr_d = rx_data[3:0];
            state_d    = S_CFG_DH;
          end else begin
            err_badhdr_d = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end
      S_CFG_DH: begin
        if (rx_rdy) begin
          consume           = 1'b1;
          cfg_data_d[15:8]  = rx_data;
          state_d           = S_CFG_DL;
        end
      end
      S_CFG_DL: begin
        if (rx_rdy) begin
          consume         = 1'b1;
          cfg_data_d[7:0] = rx_data;
          cfg_vld_d       = 1'b1;
          state_d         = S_CFG_WAIT;
        end
      end
      S_CFG_WAIT: begin
        if (cfg_ack) begin
          cfg_vld_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The receiver must never see clr_rdy while this block is held in reset.
  assign clr_rdy    = rst_n & consume;
  assign auth_vld   = auth_vld_q;
  assign auth_byte  = auth_byte_q;
  assign cfg_vld    = cfg_vld_q;
  assign cfg_addr   = cfg_addr_q;
  assign cfg_data   = cfg_data_q;
  assign err_badhdr = err_badhdr_q;
  assign err_tmo    = err_tmo_q;

endmodule
